otter_mem_arbiter: RTL and testbench
====================================

Name: otter_mem_arbiter

Overview:
- Shares the single-port OTTER main memory between two requesters: the instruction fetch port (IF) and the data load/store port (D).
- Sits between the multicycle control unit / datapath and the memory.
- Sequences each access as issue, fixed-latency wait and acknowledge, and returns read data to the requester.
- Arbitrates round-robin when both ports request, and rejects misaligned accesses without touching memory.

Parameters:
- MEM_LAT, 2, memory read latency in cycles from the M_EN cycle to valid M_RDATA. Legal range is 1..15.

Ports:
- CLK  in  1  clock
- RST  in  1  reset
- IF_REQ  in  1  fetch request, held until IF_ACK
- IF_ADDR  in  32  fetch byte address
- IF_ACK  out  1  one-cycle fetch completion pulse
- IF_RDATA  out  32  fetched instruction, valid while IF_ACK=1
- IF_ERR  out  1  misaligned fetch, valid with IF_ACK
- D_REQ  in  1  data request, held until D_ACK
- D_WE  in  1  1=store, 0=load
- D_ADDR  in  32  data byte address
- D_WDATA  in  32  store data
- D_SIZE  in  2  00=byte, 01=half, 10=word
- D_ACK  out  1  one-cycle data completion pulse
- D_RDATA  out  32  load data, valid while D_ACK=1
- D_ERR  out  1  misaligned data access, valid with D_ACK
- M_EN  out  1  memory command strobe
- M_WE  out  1  memory write enable, qualified by M_EN
- M_ADDR  out  32  memory address
- M_WDATA  out  32  memory write data
- M_SIZE  out  2  memory access size
- M_RDATA  in  32  memory read data, valid MEM_LAT cycles after the M_EN cycle
- BUSY  out  1  high in every state except IDLE

Behaviour:

Reset and clocking
- RST is synchronous and active-high; CLK is the clock.
- On RST, every output is driven to 0, state goes to IDLE and last_grant is set to IF.
- Reset mid-transaction abandons the access and any in-flight M_RDATA. No ACK is issued.
- All outputs are registered.

States: IDLE, ISSUE, WAIT, DONE.

IDLE
- With no REQ, stay in IDLE.
- With exactly one REQ high, grant that port.
- With both REQ high, grant the port opposite last_grant.
- On grant: latch addr, we, wdata and size (IF is always read/word), and update last_grant.
- If the request is misaligned, go to DONE with ERR set. Misaligned means: half with addr[0]=1, word with addr[1:0]!=0, or IF_ADDR[1:0]!=0.
- Otherwise go to ISSUE.

ISSUE (exactly one cycle)
- M_EN=1; M_WE, M_ADDR, M_WDATA and M_SIZE come from the latched values. M_ADDR is passed unmodified.
- A store goes next to DONE.
- A load or fetch goes next to WAIT.

WAIT (exactly MEM_LAT cycles)
- M_EN=0.
- On the last WAIT cycle, capture M_RDATA into the granted port's RDATA register.
- Then go to DONE.

DONE (one cycle)
- Granted port's ACK=1; ERR=1 only for a rejected access.
- RDATA holds the captured data for a load or fetch, and 0 on ERR or store.
- Next state is IDLE.

Latency, with REQ sampled in IDLE at cycle N
- Store: ACK at N+2.
- Load or fetch: ACK at N+2+MEM_LAT.
- Misaligned access: ACK+ERR at N+1.

Handshake rules
- A requester holds REQ and its operands stable until its ACK.
- A REQ still high in the IDLE cycle after an ACK is treated as a new request.
- The non-granted port's REQ waits with no ACK; it is served next when both are pending.

Register behaviour between transactions
- D_RDATA and IF_RDATA are cleared to 0 in any cycle their ACK is 0.
- M_ADDR, M_WDATA and M_SIZE hold their last values when M_EN=0.

Other rules
- D_SIZE=11 is treated as word.
- Both ports can never be acknowledged in the same cycle.
- Back-to-back fetch/data alternation gives each port at most one transaction of wait.

Test Plan:
1. MEM_LAT=2; IF_REQ=1, IF_ADDR=0x100, memory returns 0x00000013 -> M_EN=1 with M_ADDR=0x100 at N+1; IF_ACK=1 with IF_RDATA=0x00000013 at N+4; BUSY low at N+5.
2. D_REQ=1, D_WE=1, D_ADDR=0x2004, D_WDATA=0xDEADBEEF, D_SIZE=10 -> at N+1 M_EN=1, M_WE=1, M_ADDR=0x2004, M_WDATA=0xDEADBEEF; D_ACK=1 at N+2; D_ERR=0.
3. IF_REQ and D_REQ raised together after reset (D load at 0x2000 returning 0x12345678, IF at 0x104) -> D served first with D_ACK at N+4 and D_RDATA=0x12345678. IF is granted at N+5; IF_ACK at N+9. No overlapping M_EN.
4. D_REQ with D_SIZE=10, D_ADDR=0x2002 -> D_ACK=1 and D_ERR=1 at N+1, M_EN stays 0. Half at 0x2001 gives the same result; half at 0x2002 proceeds normally.
5. RST asserted during WAIT of a fetch to 0x108 -> the next cycle shows all outputs 0 and state IDLE. No IF_ACK is ever produced; a subsequent IF_REQ completes normally with full latency.
6. MEM_LAT=1 and MEM_LAT=5 builds; load to 0x3000 -> D_ACK at N+3 and N+7 respectively, with RDATA equal to M_RDATA exactly MEM_LAT cycles after M_EN.

Source files
------------

// File: rtl/otter_mem_arbiter.sv
// Round-robin arbiter sharing the single-port OTTER memory between fetch and data ports.
// Each access runs issue -> fixed-latency wait -> acknowledge; misaligned accesses are rejected without a memory cycle.
module otter_mem_arbiter #(
    parameter int MEM_LAT = 2
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        IF_REQ,
    input  logic [31:0] IF_ADDR,
    output logic        IF_ACK,
    output logic [31:0] IF_RDATA,
    output logic        IF_ERR,
    input  logic        D_REQ,
    input  logic        D_WE,
    input  logic [31:0] D_ADDR,
    input  logic [31:0] D_WDATA,
    input  logic [1:0]  D_SIZE,
    output logic        D_ACK,
    output logic [31:0] D_RDATA,
    output logic        D_ERR,
    output logic        M_EN,
    output logic        M_WE,
    output logic [31:0] M_ADDR,
    output logic [31:0] M_WDATA,
    output logic [1:0]  M_SIZE,
    input  logic [31:0] M_RDATA,
    output logic        BUSY
);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_ISSUE = 2'd1;
    localparam logic [1:0] ST_WAIT  = 2'd2;
    localparam logic [1:0] ST_DONE  = 2'd3;

    localparam logic [3:0] WAIT_LAST = 4'(MEM_LAT - 1);

    function automatic logic is_misaligned(input logic [31:0] addr, input logic [1:0] size);
        case (size)
            2'b00:   is_misaligned = 1'b0;
            2'b01:   is_misaligned = addr[0];
            default: is_misaligned = (addr[1:0] != 2'b00);
        endcase
    endfunction

    logic [1:0]  state_r;
    logic        last_grant_r;   // 0 = fetch port, 1 = data port
    logic        gnt_d_r;
    logic [3:0]  cnt_r;
    logic        if_ack_r, if_err_r, d_ack_r, d_err_r;
    logic [31:0] if_rdata_r, d_rdata_r;
    logic        m_en_r, m_we_r, busy_r;
    logic [31:0] m_addr_r, m_wdata_r;
    logic [1:0]  m_size_r;

    logic        req_any_s, grant_d_s, sel_we_s, misalign_s;
    logic [31:0] sel_addr_s, sel_wdata_s;
    logic [1:0]  sel_size_s;

    // Grant selection and operand mux for the IDLE decision
    always_comb begin
        req_any_s   = IF_REQ | D_REQ;
        grant_d_s   = D_REQ & (~IF_REQ | ~last_grant_r);
        sel_addr_s  = IF_ADDR;
        sel_wdata_s = 32'h0000_0000;
        sel_we_s    = 1'b0;
        sel_size_s  = 2'b10;
        if (grant_d_s) begin
            sel_addr_s  = D_ADDR;
            sel_wdata_s = D_WDATA;
            sel_we_s    = D_WE;
            sel_size_s  = (D_SIZE == 2'b11) ? 2'b10 : D_SIZE;
        end else begin
            sel_addr_s  = IF_ADDR;
        end
        misalign_s = is_misaligned(sel_addr_s, sel_size_s);
    end

    // Sequencer; the M_* registers double as the latched operands of the current access
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_r      <= ST_IDLE;
            last_grant_r <= 1'b0;
            gnt_d_r      <= 1'b0;
            cnt_r        <= 4'd0;
            if_ack_r     <= 1'b0;
            if_err_r     <= 1'b0;
            if_rdata_r   <= 32'h0000_0000;
            d_ack_r      <= 1'b0;
            d_err_r      <= 1'b0;
            d_rdata_r    <= 32'h0000_0000;
            m_en_r       <= 1'b0;
            m_we_r       <= 1'b0;
            m_addr_r     <= 32'h0000_0000;
            m_wdata_r    <= 32'h0000_0000;
            m_size_r     <= 2'b00;
            busy_r       <= 1'b0;
        end else begin
            if_ack_r   <= 1'b0;
            if_err_r   <= 1'b0;
            if_rdata_r <= 32'h0000_0000;
            d_ack_r    <= 1'b0;
            d_err_r    <= 1'b0;
            d_rdata_r  <= 32'h0000_0000;
            m_en_r     <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    if (req_any_s) begin
                        gnt_d_r      <= grant_d_s;
                        last_grant_r <= grant_d_s;
                        busy_r       <= 1'b1;
                        if (misalign_s) begin
                            state_r  <= ST_DONE;
                            if_ack_r <= ~grant_d_s;
                            if_err_r <= ~grant_d_s;
                            d_ack_r  <= grant_d_s;
                            d_err_r  <= grant_d_s;
                        end else begin
                            state_r   <= ST_ISSUE;
                            m_en_r    <= 1'b1;
                            m_we_r    <= sel_we_s;
                            m_addr_r  <= sel_addr_s;
                            m_wdata_r <= sel_wdata_s;
                            m_size_r  <= sel_size_s;
                        end
                    end else begin
                        busy_r <= 1'b0;
                    end
                end
                ST_ISSUE: begin
                    if (m_we_r) begin
                        state_r <= ST_DONE;
                        d_ack_r <= 1'b1;
                    end else begin
                        state_r <= ST_WAIT;
                        cnt_r   <= WAIT_LAST;
                    end
                end
                ST_WAIT: begin
                    if (cnt_r == 4'd0) begin
                        state_r <= ST_DONE;
                        if (gnt_d_r) begin
                            d_ack_r   <= 1'b1;
                            d_rdata_r <= M_RDATA;
                        end else begin
                            if_ack_r   <= 1'b1;
                            if_rdata_r <= M_RDATA;
                        end
                    end else begin
                        cnt_r <= cnt_r - 4'd1;
                    end
                end
                ST_DONE: begin
                    state_r <= ST_IDLE;
                    busy_r  <= 1'b0;
                end
                default: begin
                    state_r <= ST_IDLE;
                    busy_r  <= 1'b0;
                end
            endcase
        end
    end

    assign IF_ACK   = if_ack_r;
    assign IF_ERR   = if_err_r;
    assign IF_RDATA = if_rdata_r;
    assign D_ACK    = d_ack_r;
    assign D_ERR    = d_err_r;
    assign D_RDATA  = d_rdata_r;
    assign M_EN     = m_en_r;
    assign M_WE     = m_we_r;
    assign M_ADDR   = m_addr_r;
    assign M_WDATA  = m_wdata_r;
    assign M_SIZE   = m_size_r;
    assign BUSY     = busy_r;

endmodule

// File: tb/tb_otter_mem_arbiter.sv
// Bench for otter_mem_arbiter: three instances (MEM_LAT 1, 2, 5) each with a latency-accurate memory,
// checked against a transaction-level model of latency, grant order, error and read data.
module tb_otter_mem_arbiter;

    logic        CLK = 1'b0;
    logic        RST;
    always #5 CLK = ~CLK;

    logic        if_req [3];
    logic [31:0] if_addr [3];
    logic        d_req [3];
    logic        d_we [3];
    logic [31:0] d_addr [3];
    logic [31:0] d_wdata [3];
    logic [1:0]  d_size [3];
    logic        if_ack [3], if_err [3], d_ack [3], d_err [3];
    logic        m_en [3], m_we [3], busy [3];
    logic [31:0] if_rdata [3], d_rdata [3], m_addr [3], m_wdata [3];
    logic [1:0]  m_size [3];

    logic [31:0] ref_mem [0:4095];
    bit          lg [3];
    int          tests = 0;
    int          fails = 0;

    function automatic logic [31:0] init_word(input int unsigned idx);
        case (idx)
            32'h40:  init_word = 32'h0000_0013;
            32'h800: init_word = 32'h1234_5678;
            default: init_word = (idx * 32'h9E37_79B1) ^ 32'h5A5A_0000;
        endcase
    endfunction

    function automatic int lat_of(input int g);
        lat_of = (g == 0) ? 1 : ((g == 1) ? 2 : 5);
    endfunction

    for (genvar g = 0; g < 3; g++) begin : g_dut
        localparam int LAT = (g == 0) ? 1 : ((g == 1) ? 2 : 5);
        logic [31:0] dev [0:4095];
        logic [31:0] pipe [0:LAT-1];

        initial for (int i = 0; i < 4096; i++) dev[i] = init_word(i);

        // memory device: write on a store strobe, return read data LAT cycles after the strobe, noise otherwise
        always @(posedge CLK) begin
            if (m_en[g] && m_we[g]) dev[m_addr[g][13:2]] <= m_wdata[g];
            pipe[0] <= m_en[g] ? dev[m_addr[g][13:2]] : $urandom;
            for (int i = 1; i < LAT; i++) pipe[i] <= pipe[i-1];
        end

        otter_mem_arbiter #(.MEM_LAT(LAT)) u_dut (
            .CLK(CLK), .RST(RST),
            .IF_REQ(if_req[g]), .IF_ADDR(if_addr[g]), .IF_ACK(if_ack[g]),
            .IF_RDATA(if_rdata[g]), .IF_ERR(if_err[g]),
            .D_REQ(d_req[g]), .D_WE(d_we[g]), .D_ADDR(d_addr[g]), .D_WDATA(d_wdata[g]),
            .D_SIZE(d_size[g]), .D_ACK(d_ack[g]), .D_RDATA(d_rdata[g]), .D_ERR(d_err[g]),
            .M_EN(m_en[g]), .M_WE(m_we[g]), .M_ADDR(m_addr[g]), .M_WDATA(m_wdata[g]),
            .M_SIZE(m_size[g]), .M_RDATA(pipe[LAT-1]), .BUSY(busy[g])
        );
    end

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // one request on one port of instance g, with latency/bus/data checked against the model
    task automatic xfer(input int g, input bit is_d, input bit we, input logic [31:0] addr,
                        input logic [31:0] wdata, input logic [1:0] size);
        logic [1:0]  esz;
        logic [31:0] exp_rd, prev_addr;
        bit          ewe, bad, got;
        int          exp_lat, lat, n_en;
        esz       = is_d ? ((size == 2'b11) ? 2'b10 : size) : 2'b10;
        ewe       = is_d && we;
        bad       = (esz == 2'b01) ? addr[0] : ((esz == 2'b10) ? (addr[1:0] != 2'b00) : 1'b0);
        exp_lat   = bad ? 1 : (ewe ? 2 : 2 + lat_of(g));
        exp_rd    = (bad || ewe) ? 32'h0 : ref_mem[addr[13:2]];
        prev_addr = m_addr[g];
        if (is_d) begin
            d_req[g] = 1'b1; d_we[g] = we; d_addr[g] = addr; d_wdata[g] = wdata; d_size[g] = size;
        end else begin
            if_req[g] = 1'b1; if_addr[g] = addr;
        end
        lat = 0; n_en = 0; got = 1'b0;
        while (!got && lat < 40) begin
            tick();
            lat++;
            chk("busy", busy[g], 1);
            chk("other_ack", is_d ? if_ack[g] : d_ack[g], 0);
            if (m_en[g]) begin
                n_en++;
                chk("m_en_cycle", lat, 1);
                chk("m_addr", m_addr[g], addr);
                chk("m_we", m_we[g], ewe);
                chk("m_size", m_size[g], esz);
                if (ewe) chk("m_wdata", m_wdata[g], wdata);
            end
            got = is_d ? d_ack[g] : if_ack[g];
        end
        chk("ack_lat", lat, exp_lat);
        chk("n_m_en", n_en, bad ? 0 : 1);
        chk("err", is_d ? d_err[g] : if_err[g], bad);
        chk("rdata", is_d ? d_rdata[g] : if_rdata[g], exp_rd);
        if (bad) chk("m_addr_hold", m_addr[g], prev_addr);
        if (is_d) d_req[g] = 1'b0; else if_req[g] = 1'b0;
        if (ewe && !bad) ref_mem[addr[13:2]] = wdata;
        lg[g] = is_d;
        tick();
        chk("ack_clear", is_d ? d_ack[g] : if_ack[g], 0);
        chk("rdata_clear", is_d ? d_rdata[g] : if_rdata[g], 0);
        chk("idle", busy[g], 0);
    endtask

    // both ports request together; the model decides the order from the last grant
    task automatic both(input int g, input bit dwe, input logic [31:0] daddr,
                        input logic [31:0] dwdata, input logic [31:0] iaddr);
        bit          d_first, dg, ig;
        int          dl, il, exp_d, exp_i, d_at, i_at, lat, n_en;
        logic [31:0] exp_drd, exp_ird;
        d_first = !lg[g];
        dl      = dwe ? 2 : 2 + lat_of(g);
        il      = 2 + lat_of(g);
        exp_d   = d_first ? dl : il + 1 + dl;
        exp_i   = d_first ? dl + 1 + il : il;
        exp_drd = dwe ? 32'h0 : ref_mem[daddr[13:2]];
        exp_ird = ref_mem[iaddr[13:2]];
        d_req[g] = 1'b1; d_we[g] = dwe; d_addr[g] = daddr; d_wdata[g] = dwdata; d_size[g] = 2'b10;
        if_req[g] = 1'b1; if_addr[g] = iaddr;
        dg = 1'b0; ig = 1'b0; d_at = 0; i_at = 0; lat = 0; n_en = 0;
        while (!(dg && ig) && lat < 80) begin
            tick();
            lat++;
            chk("dual_ack", if_ack[g] & d_ack[g], 0);
            if (m_en[g]) n_en++;
            if (d_ack[g] && !dg) begin
                dg = 1'b1; d_at = lat; d_req[g] = 1'b0;
                chk("both_d_rdata", d_rdata[g], exp_drd);
            end
            if (if_ack[g] && !ig) begin
                ig = 1'b1; i_at = lat; if_req[g] = 1'b0;
                chk("both_if_rdata", if_rdata[g], exp_ird);
            end
        end
        chk("both_d_lat", d_at, exp_d);
        chk("both_if_lat", i_at, exp_i);
        chk("both_n_m_en", n_en, 2);
        if (dwe) ref_mem[daddr[13:2]] = dwdata;
        lg[g] = !d_first;
        tick();
        chk("both_idle", busy[g], 0);
    endtask

    initial begin
        RST = 1'b1;
        for (int i = 0; i < 3; i++) begin
            if_req[i] = 1'b0; if_addr[i] = 32'h0; d_req[i] = 1'b0; d_we[i] = 1'b0;
            d_addr[i] = 32'h0; d_wdata[i] = 32'h0; d_size[i] = 2'b10; lg[i] = 1'b0;
        end
        for (int i = 0; i < 4096; i++) ref_mem[i] = init_word(i);
        tick();
        tick();
        chk("rst_if_ack", if_ack[1], 0);
        chk("rst_d_ack", d_ack[1], 0);
        chk("rst_m_en", m_en[1], 0);
        chk("rst_m_addr", m_addr[1], 0);
        chk("rst_busy", busy[1], 0);
        RST = 1'b0;

        // fetch, store, read-back, misaligned and half-word boundaries
        xfer(1, 1'b0, 1'b0, 32'h100, 32'h0, 2'b10);
        xfer(1, 1'b1, 1'b1, 32'h2004, 32'hDEAD_BEEF, 2'b10);
        xfer(1, 1'b1, 1'b0, 32'h2004, 32'h0, 2'b10);
        xfer(1, 1'b1, 1'b0, 32'h2002, 32'h0, 2'b10);
        xfer(1, 1'b1, 1'b0, 32'h2001, 32'h0, 2'b01);
        xfer(1, 1'b1, 1'b0, 32'h2002, 32'h0, 2'b01);
        xfer(1, 1'b1, 1'b0, 32'h2003, 32'h0, 2'b00);
        xfer(1, 1'b1, 1'b0, 32'h2006, 32'h0, 2'b11);
        xfer(1, 1'b0, 1'b0, 32'h102, 32'h0, 2'b10);

        // reset in the middle of a fetch's wait
        if_req[1] = 1'b1; if_addr[1] = 32'h108;
        tick(); tick(); tick();
        RST = 1'b1; if_req[1] = 1'b0;
        tick();
        chk("mid_rst_if_ack", if_ack[1], 0);
        chk("mid_rst_if_rdata", if_rdata[1], 0);
        chk("mid_rst_m_en", m_en[1], 0);
        chk("mid_rst_m_addr", m_addr[1], 0);
        chk("mid_rst_m_size", m_size[1], 0);
        chk("mid_rst_busy", busy[1], 0);
        RST = 1'b0;
        for (int i = 0; i < 3; i++) lg[i] = 1'b0;
        for (int k = 0; k < 6; k++) begin
            tick();
            chk("no_stale_ack", if_ack[1], 0);
        end

        // simultaneous requests right after reset: data port first
        both(1, 1'b0, 32'h2000, 32'h0, 32'h104);
        xfer(1, 1'b0, 1'b0, 32'h108, 32'h0, 2'b10);

        // randomized single transactions; stores stay clear of the fetch region
        for (int k = 0; k < 40; k++) begin
            if ($urandom_range(0, 1) == 1)
                xfer(1, 1'b1, 1'($urandom_range(0, 1)), 32'h1000 + $urandom_range(0, 1023),
                     $urandom, 2'($urandom_range(0, 3)));
            else
                xfer(1, 1'b0, 1'b0, 32'($urandom_range(0, 1023)), 32'h0, 2'b10);
        end
        // randomized contention
        for (int k = 0; k < 15; k++) begin
            both(1, 1'($urandom_range(0, 1)), 32'h1000 + 32'($urandom_range(0, 255)) * 4,
                 $urandom, 32'($urandom_range(0, 255)) * 4);
        end

        // other latency builds
        xfer(0, 1'b1, 1'b0, 32'h3000, 32'h0, 2'b10);
        xfer(2, 1'b1, 1'b0, 32'h3000, 32'h0, 2'b10);
        xfer(0, 1'b0, 1'b0, 32'h100, 32'h0, 2'b10);
        xfer(2, 1'b0, 1'b0, 32'h104, 32'h0, 2'b10);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
